fir_interp_sched: RTL and testbench

Sequencer for the polyphase FIR interpolation CPU. It generates the output-rate request strobe (`data_req_i` of the CPU) every programmed number of clocks. On phase 0 it issues the input-sample strobe (`data_val_i`) in the same cycle as the request. It also buffers upstream samples behind a valid/ready handshake and re-times the CPU output into a valid-qualified stream. It enforces the CPU timing rules: `data_val` only together with `data_req`, exactly INTERPOLATION requests per input sample, and a request spacing no shorter than the compute time.

---
 rtl/fir_interp_sched.sv | 249 ++++++++++++++++++++++++
 tb/tb_fir_interp_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_interp_sched.sv
// Request/phase sequencer for the polyphase FIR interpolation CPU. It includes a
// 2-entry upstream sample FIFO and re-times the CPU result into a valid-qualified stream.
module fir_interp_sched #(
  parameter int FILTER_ORDER  = 256,
  parameter int INTERPOLATION = 32,
  parameter int DATA_WIDTH    = 16,
  parameter int OUT_WIDTH     = 16,
  parameter int PERIOD_WIDTH  = 16,
  parameter int MIN_PERIOD    = FILTER_ORDER / INTERPOLATION + 5
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic [PERIOD_WIDTH-1:0]          period_i,
  input  logic                             clr_err_i,
  input  logic [DATA_WIDTH-1:0]            s_data_i,
  input  logic                             s_valid_i,
  output logic                             s_ready_o,
  output logic [DATA_WIDTH-1:0]            fir_data_o,
  output logic                             fir_val_o,
  output logic                             fir_req_o,
  input  logic [OUT_WIDTH-1:0]             fir_data_i,
  output logic [OUT_WIDTH-1:0]             out_data_o,
  output logic                             out_valid_o,
  output logic [$clog2(INTERPOLATION)-1:0] phase_o,
  output logic                             underflow_o,
  output logic                             cfg_err_o
);

  localparam int PH_W = $clog2(INTERPOLATION);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P   = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PH_W-1:0]         LAST_PH = PH_W'(INTERPOLATION - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] p_eff_q, p_eff_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    fir_req_q, fir_req_d;
  logic                    fir_val_q, fir_val_d;
  logic [DATA_WIDTH-1:0]   fir_data_q, fir_data_d;
  logic                    req_dly_q, req_dly_d;
  logic                    first_q, first_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
  logic                    underflow_q, underflow_d;
  logic                    cfg_err_q, cfg_err_d;
  logic [DATA_WIDTH-1:0]   mem0_q, mem0_d, mem1_q, mem1_d;
  logic                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    rdy_q, rdy_d;

  logic                  push_s, pop_s, empty_s, full_s, short_s, tick_s;
  logic                  issue_s, latch_s, entry_s, uf_set_s, cfg_set_s;
  logic [PH_W-1:0]       next_ph_s;
  logic [DATA_WIDTH-1:0] head_s;

  assign empty_s   = (count_q == 2'd0);
  assign full_s    = (count_q == 2'd2);
  assign head_s    = rd_ptr_q ? mem1_q : mem0_q;
  // rdy_q keeps s_ready_o low while reset is applied and for the first clock after.
  assign s_ready_o = rdy_q && !full_s;
  assign push_s    = s_valid_i && s_ready_o;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_eff_d     = p_eff_q;
    phase_d     = phase_q;
    fir_req_d   = 1'b0;
    fir_val_d   = 1'b0;
    fir_data_d  = fir_data_q;
    req_dly_d   = fir_req_q;
    first_d     = first_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    issue_s     = 1'b0;
    latch_s     = 1'b0;
    entry_s     = 1'b0;
    uf_set_s    = 1'b0;
    cfg_set_s   = 1'b0;
    pop_s       = 1'b0;
    short_s     = (period_i < MIN_P);
    tick_s      = (cnt_q >= (p_eff_q - PERIOD_WIDTH'(1)));
    next_ph_s   = (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_i) begin
          state_d   = RUN;
          latch_s   = 1'b1;
          issue_s   = 1'b1;
          entry_s   = 1'b1;
          next_ph_s = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN, STOP: begin
        state_d = en_i ? RUN : STOP;
        cnt_d   = tick_s ? '0 : cnt_q + PERIOD_WIDTH'(1);
        if (tick_s) begin
          // Stopping only completes on a sample boundary, so the CPU sees whole input periods.
          if (!en_i && (phase_q == LAST_PH)) begin
            state_d = IDLE;
          end else begin
            latch_s = 1'b1;
            issue_s = 1'b1;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (latch_s) begin
      p_eff_d   = short_s ? MIN_P : period_i;
      cfg_set_s = short_s;
    end else begin
      p_eff_d = p_eff_q;
    end

    if (issue_s) begin
      fir_req_d = 1'b1;
      phase_d   = next_ph_s;
      if (next_ph_s == '0) begin
        // Zero-stuff on underflow so the polyphase alignment is kept.
        fir_val_d = 1'b1;
        if (empty_s) begin
          fir_data_d = '0;
          uf_set_s   = 1'b1;
        end else begin
          fir_data_d = head_s;
          pop_s      = 1'b1;
        end
      end else begin
        fir_val_d = 1'b0;
      end
    end else begin
      fir_req_d = 1'b0;
    end

    // CPU result of request k is valid the cycle after request k+1.
    if (req_dly_q) begin
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = fir_data_i;
      end
    end else begin
      out_valid_d = 1'b0;
    end
    if (entry_s) begin
      first_d = 1'b1;
    end else begin
      first_d = first_d;
    end

    underflow_d = uf_set_s  || (underflow_q && !clr_err_i);
    cfg_err_d   = cfg_set_s || (cfg_err_q && !clr_err_i);
  end

  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdy_d    = 1'b1;
    if (push_s) begin
      if (wr_ptr_q) begin
        mem1_d = s_data_i;
      end else begin
        mem0_d = s_data_i;
      end
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_eff_q     <= MIN_P;
      phase_q     <= '0;
      fir_req_q   <= 1'b0;
      fir_val_q   <= 1'b0;
      fir_data_q  <= '0;
      req_dly_q   <= 1'b0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      underflow_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      mem0_q      <= '0;
      mem1_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_eff_q     <= p_eff_d;
      phase_q     <= phase_d;
      fir_req_q   <= fir_req_d;
      fir_val_q   <= fir_val_d;
      fir_data_q  <= fir_data_d;
      req_dly_q   <= req_dly_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      underflow_q <= underflow_d;
      cfg_err_q   <= cfg_err_d;
      mem0_q      <= mem0_d;
      mem1_q      <= mem1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdy_q       <= rdy_d;
    end
  end

  assign fir_req_o   = fir_req_q;
  assign fir_val_o   = fir_val_q;
  assign fir_data_o  = fir_data_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign phase_o     = phase_q;
  assign underflow_o = underflow_q;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_fir_interp_sched.sv
// Directed bench for fir_interp_sched: request spacing, phases, FIFO, re-timing,
// status flags, stop/restart and asynchronous reset.
module tb_fir_interp_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [15:0] period_i;
  logic        clr_err_i;
  logic [15:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [15:0] fir_data_o;
  logic        fir_val_o;
  logic        fir_req_o;
  logic [15:0] fir_data_i;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic [4:0]  phase_o;
  logic        underflow_o;
  logic        cfg_err_o;

  int errors = 0;
  int checks = 0;
  int nreq, nout, nbad;

  fir_interp_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .period_i(period_i),
    .clr_err_i(clr_err_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .fir_data_o(fir_data_o), .fir_val_o(fir_val_o),
    .fir_req_o(fir_req_o), .fir_data_i(fir_data_i), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o), .phase_o(phase_o), .underflow_o(underflow_o),
    .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Steps n cycles counting requests and output strobes; checks phase order and val-without-req.
  task automatic window(input int n, input logic [4:0] ph0,
                        output int req_cnt, output int out_cnt, output int bad_cnt);
    logic [4:0] ph;
    ph = ph0; req_cnt = 0; out_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (fir_req_o) begin
        req_cnt++;
        if (phase_o !== ph) bad_cnt++;
        ph = ph + 5'd1;
      end
      if (fir_val_o && !fir_req_o) bad_cnt++;
      if (out_valid_o) out_cnt++;
    end
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; period_i = 16'd40; clr_err_i = 1'b0;
    s_data_i = 16'h0; s_valid_i = 1'b0; fir_data_i = 16'h0;
    #1;
    check("rst_req", fir_req_o, 0);
    check("rst_val", fir_val_o, 0);
    check("rst_data", fir_data_o, 0);
    check("rst_ovalid", out_valid_o, 0);
    check("rst_odata", out_data_o, 0);
    check("rst_phase", phase_o, 0);
    check("rst_uflow", underflow_o, 0);
    check("rst_cfgerr", cfg_err_o, 0);
    check("rst_ready", s_ready_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    step(1);
    check("ready_after_rst", s_ready_o, 1);

    // Preload two samples, third is refused
    s_data_i = 16'h1234; s_valid_i = 1'b1; step(1);
    s_data_i = 16'h5678; step(1);
    check("fifo_full", s_ready_o, 0);
    s_data_i = 16'h9999; step(2);
    check("fifo_full_hold", s_ready_o, 0);
    s_valid_i = 1'b0;

    // Start: period 40
    en_i = 1'b1; step(1);
    check("req1", fir_req_o, 1);
    check("req1_val", fir_val_o, 1);
    check("req1_data", fir_data_o, 16'h1234);
    check("req1_phase", phase_o, 0);
    check("ready_after_pop", s_ready_o, 1);
    step(2);
    check("first_out_suppressed", out_valid_o, 0);
    step(37);
    check("req_gap", fir_req_o, 0);
    step(1);
    check("req2", fir_req_o, 1);
    check("req2_phase", phase_o, 1);
    check("req2_val", fir_val_o, 0);
    check("data_hold", fir_data_o, 16'h1234);
    fir_data_i = 16'h1111; step(1);
    fir_data_i = 16'hBEEF;
    check("out_not_yet", out_valid_o, 0);
    step(1);
    fir_data_i = 16'h2222;
    check("out_valid_req2p2", out_valid_o, 1);
    check("out_data_capture", out_data_o, 16'hBEEF);
    step(1);
    check("out_valid_one_cycle", out_valid_o, 0);

    window(1237, 5'd2, nreq, nout, nbad);
    check("win1_reqs", nreq, 31);
    check("win1_outs", nout, 30);
    check("win1_bad", nbad, 0);
    check("req33", fir_req_o, 1);
    check("req33_val", fir_val_o, 1);
    check("req33_data", fir_data_o, 16'h5678);
    check("req33_phase", phase_o, 0);

    // Short period clamps to MIN_PERIOD and flags
    period_i = 16'd4; step(40);
    check("req_p4_latch", fir_req_o, 1);
    check("cfg_err_set", cfg_err_o, 1);
    step(12);
    check("min_gap", fir_req_o, 0);
    step(1);
    check("min_period_req", fir_req_o, 1);
    clr_err_i = 1'b1; period_i = 16'd20; step(1);
    clr_err_i = 1'b0;
    check("cfg_err_clr", cfg_err_o, 0);
    step(12);
    check("req_after_13", fir_req_o, 1);
    step(19);
    check("gap20", fir_req_o, 0);
    step(1);
    check("req_p20", fir_req_o, 1);
    check("req_p20_phase", phase_o, 4);
    check("cfg_err_stays_clr", cfg_err_o, 0);

    // Underflow at next phase 0, with a simultaneous clear request
    step(559);
    check("pre_uf_req", fir_req_o, 0);
    check("pre_uf_flag", underflow_o, 0);
    clr_err_i = 1'b1; step(1);
    clr_err_i = 1'b0;
    check("uf_req", fir_req_o, 1);
    check("uf_val", fir_val_o, 1);
    check("uf_data_zero", fir_data_o, 0);
    check("uf_phase", phase_o, 0);
    check("uf_set_wins", underflow_o, 1);
    s_data_i = 16'h4242; s_valid_i = 1'b1; step(1);
    s_valid_i = 1'b0; clr_err_i = 1'b1; step(1);
    clr_err_i = 1'b0;
    check("uf_clr", underflow_o, 0);
    step(638);
    check("norm_req", fir_req_o, 1);
    check("norm_val", fir_val_o, 1);
    check("norm_data", fir_data_o, 16'h4242);
    check("norm_phase", phase_o, 0);
    check("norm_uflow", underflow_o, 0);

    // Drop enable at phase 10
    step(200);
    check("ph10_req", fir_req_o, 1);
    check("ph10_phase", phase_o, 10);
    en_i = 1'b0;
    window(534, 5'd11, nreq, nout, nbad);
    check("stop_reqs", nreq, 21);
    check("stop_outs", nout, 22);
    check("stop_bad", nbad, 0);
    check("stop_last_phase", phase_o, 31);

    // Restart with two samples queued
    s_data_i = 16'h7777; s_valid_i = 1'b1; step(1);
    s_data_i = 16'h5555; step(1);
    s_valid_i = 1'b0;
    en_i = 1'b1; step(1);
    check("restart_req", fir_req_o, 1);
    check("restart_val", fir_val_o, 1);
    check("restart_data", fir_data_o, 16'h7777);
    check("restart_phase", phase_o, 0);

    // Asynchronous reset in the request cycle
    #2 rst_i = 1'b1;
    #1;
    check("arst_req", fir_req_o, 0);
    check("arst_val", fir_val_o, 0);
    check("arst_data", fir_data_o, 0);
    check("arst_odata", out_data_o, 0);
    check("arst_ready", s_ready_o, 0);
    check("arst_cfgerr", cfg_err_o, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    step(1);
    check("post_rst_req", fir_req_o, 1);
    check("post_rst_val", fir_val_o, 1);
    check("post_rst_fifo_empty", fir_data_o, 0);
    check("post_rst_phase", phase_o, 0);
    check("post_rst_uflow", underflow_o, 1);
    check("post_rst_ready", s_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
